// File: rtl/wb_write_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and constants for the write-back scheduler.
//                wb_entry_t is the canonical layout of one queued write
//                (destination register + result); REG_ZERO is the hard-wired
//                zero register whose writes are dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int WB_AW = 4;
    localparam int WB_DW = 32;

    typedef struct packed {
        logic [WB_AW-1:0] addr;
        logic [WB_DW-1:0] data;
    } wb_entry_t;

    localparam logic [WB_AW-1:0] REG_ZERO = '0;

endpackage
`default_nettype wire

// File: rtl/wb_write_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_scheduler_if
//  Description : Bundle between the two issue lanes / register-file port and
//                the write-back scheduler.
//                  master : issue side (drives lanes, flush, port_hold) and
//                           observes the register-file write port
//                  slave  : the scheduler
//                Signals: flush, in_ready, l0_{valid,addr,data},
//                l1_{valid,addr,data}, port_hold, wr_en, wr_sel, wr_data,
//                pending.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_write_scheduler_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 32
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          in_ready;
    logic          l0_valid;
    logic [AW-1:0] l0_addr;
    logic [DW-1:0] l0_data;
    logic          l1_valid;
    logic [AW-1:0] l1_addr;
    logic [DW-1:0] l1_data;
    logic          port_hold;
    logic          wr_en;
    logic [AW-1:0] wr_sel;
    logic [DW-1:0] wr_data;
    logic [CW-1:0] pending;

    modport master (
        output flush, l0_valid, l0_addr, l0_data,
               l1_valid, l1_addr, l1_data, port_hold,
        input  in_ready, wr_en, wr_sel, wr_data, pending
    );

    modport slave (
        input  flush, l0_valid, l0_addr, l0_data,
               l1_valid, l1_addr, l1_data, port_hold,
        output in_ready, wr_en, wr_sel, wr_data, pending
    );

endinterface
`default_nettype wire

// File: rtl/wb_write_scheduler_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_fifo_2w1r
//  Description : Circular buffer accepting up to two writes and one read per
//                cycle, with an explicit occupancy counter.
//  Ports       : clk, rst      - clock / synchronous active-high reset
//                i_flush       - drop all contents (same-cycle pushes too)
//                i_push_a/b    - push requests; b is only honoured with a and
//                                lands one slot after a
//                i_entry_a/b   - entries to push
//                i_pop         - advance the read pointer
//                o_head        - entry at the read pointer, zero when empty
//                o_count       - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo_2w1r #(
    parameter int DEPTH = 4,
    parameter int EW    = 36
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_flush,
    input  wire logic                       i_push_a,
    input  wire logic [EW-1:0]              i_entry_a,
    input  wire logic                       i_push_b,
    input  wire logic [EW-1:0]              i_entry_b,
    input  wire logic                       i_pop,
    output logic      [EW-1:0]              o_head,
    output logic      [$clog2(DEPTH):0]     o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = CW + 1;

    logic [EW-1:0] r_mem_q [DEPTH];
    logic [EW-1:0] w_mem_d [DEPTH];
    logic [PW-1:0] r_wr_ptr_q, w_wr_ptr_d;
    logic [PW-1:0] r_rd_ptr_q, w_rd_ptr_d;
    logic [PW-1:0] w_wr_ptr_nxt;
    logic [CW-1:0] r_count_q, w_count_d;
    logic [SW-1:0] w_count_sum;
    logic [1:0]    w_n_push;

    // Number of pushes this cycle: 2'b10 for a pair, 2'b01 for a single.
    assign w_n_push     = {i_push_a & i_push_b, i_push_a & ~i_push_b};
    assign w_wr_ptr_nxt = r_wr_ptr_q + PW'(1);
    // One bit wider than the counter so an overflow would be visible.
    assign w_count_sum  = {1'b0, r_count_q} + SW'(w_n_push) - SW'(i_pop);

    always_comb begin
        w_mem_d    = r_mem_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;
        if (i_flush) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (i_push_a) begin
                w_mem_d[r_wr_ptr_q] = i_entry_a;
            end
            if (i_push_a && i_push_b) begin
                w_mem_d[w_wr_ptr_nxt] = i_entry_b;
            end
            // Pointer width wraps naturally modulo DEPTH.
            w_wr_ptr_d = r_wr_ptr_q + PW'(w_n_push);
            w_rd_ptr_d = r_rd_ptr_q + PW'(i_pop);
            w_count_d  = w_count_sum[CW-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_q[i] <= '0;
            end
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_count_q  <= w_count_d;
            r_mem_q    <= w_mem_d;
        end
    end

    assign o_head  = (r_count_q != '0) ? r_mem_q[r_rd_ptr_q] : '0;
    assign o_count = r_count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || i_flush)
        w_count_sum <= SW'(DEPTH));

    a_no_underflow: assert property (@(posedge clk) disable iff (rst || i_flush)
        i_pop |-> (r_count_q != '0));

endmodule
`default_nettype wire

// File: rtl/wb_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : wb_write_scheduler
//  Description : Funnels write-backs from the two issue lanes onto the single
//                register-file write port (1-to-16 demux). Writes are queued
//                in program order (lane0 before lane1) and drained one per
//                cycle; writes to register 0 are dropped.
//  Ports       : clk, rst      - clock / synchronous active-high reset
//                bus (slave)   - lane requests, flush, port_hold in;
//                                in_ready, wr_en, wr_sel, wr_data, pending out
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_write_scheduler
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WB_AW,
    parameter int DW    = WB_DW
) (
    input wire logic             clk,
    input wire logic             rst,
    wb_write_scheduler_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = AW + DW;

    logic [CW-1:0] w_count;
    logic [EW-1:0] w_head;
    logic          w_in_ready;
    logic          w_eff0;
    logic          w_eff1;
    logic          w_push_a;
    logic          w_push_b;
    logic [EW-1:0] w_entry_a;
    logic [EW-1:0] w_entry_b;
    logic          w_pop;

    // Room for a full pair, from registered occupancy only, so the lanes
    // never see a path from their own valids back to in_ready.
    assign w_in_ready = (CW'(DEPTH) - w_count) >= CW'(2);

    assign w_eff0 = bus.l0_valid && w_in_ready && (bus.l0_addr != AW'(REG_ZERO));
    assign w_eff1 = bus.l1_valid && w_in_ready && (bus.l1_addr != AW'(REG_ZERO));

    // Compact the effective lanes so the older one always takes slot wr_ptr.
    assign w_push_a  = w_eff0 | w_eff1;
    assign w_push_b  = w_eff0 & w_eff1;
    assign w_entry_a = w_eff0 ? {bus.l0_addr, bus.l0_data} : {bus.l1_addr, bus.l1_data};
    assign w_entry_b = {bus.l1_addr, bus.l1_data};

    // Reset also blocks the strobe so a reset mid-drain never leaks a write.
    assign w_pop = (w_count != '0) && !bus.port_hold && !bus.flush && !rst;

    wb_fifo_2w1r #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (bus.flush),
        .i_push_a  (w_push_a),
        .i_entry_a (w_entry_a),
        .i_push_b  (w_push_b),
        .i_entry_b (w_entry_b),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_count   (w_count)
    );

    assign bus.in_ready = w_in_ready;
    assign bus.wr_en    = w_pop;
    assign bus.wr_sel   = rst ? '0 : w_head[EW-1:DW];
    assign bus.wr_data  = rst ? '0 : w_head[DW-1:0];
    assign bus.pending  = w_count;

endmodule
`default_nettype wire

// File: doc/wb_write_scheduler.md
Name: wb_write_scheduler

Overview:
- Schedules register-file write-backs from the two issue lanes of the 2-issue superscalar core onto the single shared 32-bit write port.
- The write port is a 1-to-16 demux of 32-bit data, addressed by a 4-bit register index.
- Buffers up to DEPTH pending writes in program order (lane0 older than lane1 within a cycle) and drains one write per cycle.
- Drives the demux select, data and write-enable directly.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- AW, 4, register index width (16 registers).
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous discard of all pending writes.
- in_ready  out  1  both lanes may present writes this cycle.
- l0_valid  in  1  lane0 write request.
- l0_addr  in  AW  lane0 destination register.
- l0_data  in  DW  lane0 result.
- l1_valid  in  1  lane1 write request (younger than lane0).
- l1_addr  in  AW  lane1 destination register.
- l1_data  in  DW  lane1 result.
- port_hold  in  1  write port unavailable this cycle.
- wr_en  out  1  write strobe to the register file.
- wr_sel  out  AW  demux select.
- wr_data  out  DW  demux data input.
- pending  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage is a circular FIFO with wr_ptr, rd_ptr and a count register. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- in_ready = (DEPTH - count) >= 2, computed from registered count only. It has no combinational path from any *_valid input.
- Filtering: a lane write is effective when lane_valid && in_ready && lane_addr != 0. Writes to register 0 are silently dropped and consume no entry.
- Enqueue order on the same edge:
  - Both lanes effective: lane0 goes to slot wr_ptr, lane1 to slot wr_ptr+1, and wr_ptr advances by 2.
  - Only one lane effective: it takes slot wr_ptr and wr_ptr advances by 1.
- Valid while in_ready=0 is ignored. The requester must hold its request; nothing is captured.
- Output is combinational from the head entry:
  - wr_en = (count != 0) && !port_hold && !flush.
  - wr_sel and wr_data come from mem[rd_ptr] when count != 0, otherwise 0.
- Dequeue: when wr_en=1, rd_ptr advances by 1 at the edge.
- Next-state count = count + pushes (0, 1 or 2) - pop (0 or 1). Simultaneous push and pop is legal, including when count = DEPTH-2 with 2 pushes and 1 pop.
- Latency: a request valid at cycle t appears on wr_en at cycle t+1 at the earliest, provided the FIFO was empty and port_hold=0.
- Same-address writes are never merged. They drain in program order, so the younger value lands last.
- port_hold=1 freezes rd_ptr. Enqueue continues while in_ready permits.
- flush=1:
  - Sets count, wr_ptr and rd_ptr to 0 at the edge.
  - Same-cycle pushes are discarded.
  - wr_en is forced to 0 in the flush cycle.
- rst=1 has priority over flush:
  - count, wr_ptr and rd_ptr are set to 0 and all memory entries cleared.
  - Outputs during and after reset: wr_en=0, wr_sel=0, wr_data=0, pending=0, in_ready=1 (DEPTH>=2).
- Reset asserted mid-drain discards pending writes with no partial write.
- Overflow is impossible by construction. If count would exceed DEPTH, that is a design error and is covered by an assertion.

Decomposition:
- Shared package wb_pkg holds:
  - typedef wb_entry_t {logic [AW-1:0] addr; logic [DW-1:0] data;}.
  - localparam REG_ZERO = '0.
- One sub-module, wb_fifo_2w1r: the 2-write/1-read circular buffer with count.
- The top level holds the x0 filtering, in_ready and wr_en gating.
- Outputs connect directly to demux_1X16_32bit (sel, D), with wr_en gating the register file write.

Test Plan:
- Reset, then a single lane0 write of addr 5, data 0xDEADBEEF at cycle 1 → at cycle 2 wr_en=1, wr_sel=5, wr_data=0xDEADBEEF; cycle 3 wr_en=0, pending=0.
- Both lanes in the same cycle: l0 (3, 0x11), l1 (3, 0x22) → wr_en on two consecutive cycles, sel=3 with 0x11 then 0x22; the final register value is 0x22.
- port_hold=1 while pushing pairs for 2 cycles (DEPTH=4) → pending=4 and in_ready=0. Releasing the hold drains 4 writes in order, and in_ready returns to 1 when pending<=2.
- l0_addr=0 with l1 (7, 0xA5A5A5A5) → only one entry is queued (pending=1) and a single write sel=7.
- Fill 3 entries, then assert flush with new valid inputs in the same cycle → next cycle pending=0, wr_en=0, and no flushed or same-cycle data is ever written.
- rst asserted mid-drain with pending=2 → next cycle wr_en=0, wr_sel=0, wr_data=0, pending=0, in_ready=1.
